// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, state encoding and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic uart_parity(input logic [DATA_BITS-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level request interface of the UART transmitter plus its serial line.
// Handshake: a byte is accepted on the rising edge where start && ready; data is
// sampled only on that edge, busy == ~ready, done pulses once when the frame ends.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 start;
  logic                 ready;
  logic                 busy;
  logic                 tx;
  logic                 done;

  modport master (
    output data,
    output start,
    input  ready,
    input  busy,
    input  tx,
    input  done
  );

  modport slave (
    input  data,
    input  start,
    output ready,
    output busy,
    output tx,
    output done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// A synchronous clear holds it at zero so each bit starts a full period.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = ~clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// All line and status outputs come straight from registers.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           idx;
  logic                 parity_bit;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tick;
  logic                 baud_clr;

  // Idle holds the counter at zero, so the start bit gets a full period after
  // acceptance; every other state entry happens on a tick, which wraps it to zero.
  assign baud_clr = (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      idx        <= '0;
      parity_bit <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (bus.start) begin
            shift      <= bus.data;
            parity_bit <= uart_parity(bus.data, PARITY_ODD != 0);
            idx        <= '0;
            tx_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q  <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx_q  <= parity_bit;
                state <= PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= STOP;
              end
            end else begin
              // Next bit is shift[1] because the shift lands on this same edge.
              tx_q <= shift[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q  <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (tick) begin
            // idx wrapped to zero leaving DATA and is reused to count stop bits.
            if (idx == LAST_STOP) begin
              idx     <= '0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations driven with directed and random bytes,
// each frame compared cycle by cycle against a bit-list model of the frame format.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_v [3];
  logic [7:0] data_v  [3];
  logic       tx_v    [3];
  logic       done_v  [3];
  logic       ready_v [3];
  logic       busy_v  [3];
  logic [2:0] st_v    [3];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [0:0] exp_q[$];

  uart_tx_if bus0 ();
  uart_tx_if bus1 ();
  uart_tx_if bus2 ();

  assign bus0.start = start_v[0];
  assign bus0.data  = data_v[0];
  assign tx_v[0]    = bus0.tx;
  assign done_v[0]  = bus0.done;
  assign ready_v[0] = bus0.ready;
  assign busy_v[0]  = bus0.busy;

  assign bus1.start = start_v[1];
  assign bus1.data  = data_v[1];
  assign tx_v[1]    = bus1.tx;
  assign done_v[1]  = bus1.done;
  assign ready_v[1] = bus1.ready;
  assign busy_v[1]  = bus1.busy;

  assign bus2.start = start_v[2];
  assign bus2.data  = data_v[2];
  assign tx_v[2]    = bus2.tx;
  assign done_v[2]  = bus2.done;
  assign ready_v[2] = bus2.ready;
  assign busy_v[2]  = bus2.busy;

  uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(st_v[0]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(st_v[1]));
  uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .state_dbg(st_v[2]));

  function automatic int cpb(input int k);
    return (k == 1) ? 4 : 1;
  endfunction
  function automatic int pen(input int k);
    return (k == 2) ? 0 : 1;
  endfunction
  function automatic int podd(input int k);
    return (k == 1) ? 1 : 0;
  endfunction
  function automatic int stopb(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One entry per bit period of the whole frame.
  task automatic build_frame(input int k, input logic [7:0] d);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pen(k) != 0) exp_q.push_back(1'(($countones(d) + podd(k)) % 2));
    for (int s = 0; s < stopb(k); s++) exp_q.push_back(1'b1);
  endtask

  task automatic check_idle(input int k, input string tag);
    chk($sformatf("c%0d %s tx", k, tag), tx_v[k], 1);
    chk($sformatf("c%0d %s ready", k, tag), ready_v[k], 1);
    chk($sformatf("c%0d %s busy", k, tag), busy_v[k], 0);
    chk($sformatf("c%0d %s done", k, tag), done_v[k], 0);
    chk($sformatf("c%0d %s state", k, tag), st_v[k], 0);
  endtask

  task automatic launch(input int k, input logic [7:0] d);
    @(negedge clk);
    data_v[k]  = d;
    start_v[k] = 1'b1;
  endtask

  // Expects start/data already presented; the next rising edge is the acceptance edge.
  task automatic run_frame(input int k, input logic [7:0] d, input logic [7:0] d_after,
                           input bit poke_start, input bit hold_start);
    int c;
    int f;
    c = cpb(k);
    build_frame(k, d);
    f = exp_q.size() * c;
    @(posedge clk);
    for (int j = 0; j < f; j++) begin
      @(negedge clk);
      if (j == 0) begin
        data_v[k]  = d_after;
        start_v[k] = hold_start;
      end
      if (poke_start && j == f / 2) start_v[k] = 1'b1;
      if (poke_start && j == f / 2 + 1) start_v[k] = 1'b0;
      chk($sformatf("c%0d d%02h tx@%0d", k, d, j), tx_v[k], exp_q[j / c]);
      chk($sformatf("c%0d d%02h busy@%0d", k, d, j), busy_v[k], 1);
      chk($sformatf("c%0d d%02h ready@%0d", k, d, j), ready_v[k], 0);
      chk($sformatf("c%0d d%02h done@%0d", k, d, j), done_v[k], 0);
    end
    @(negedge clk);
    chk($sformatf("c%0d d%02h done_pulse", k, d), done_v[k], 1);
    chk($sformatf("c%0d d%02h done_ready", k, d), ready_v[k], 1);
    chk($sformatf("c%0d d%02h done_busy", k, d), busy_v[k], 0);
    chk($sformatf("c%0d d%02h done_tx", k, d), tx_v[k], 1);
    if (!hold_start) begin
      @(negedge clk);
      check_idle(k, $sformatf("d%02h after", d));
    end
  endtask

  initial begin
    logic [7:0] d;
    int k;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      data_v[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "post_reset");

    // Even parity, one bit per clock.
    launch(0, 8'hA5);
    run_frame(0, 8'hA5, 8'h00, 1'b0, 1'b0);

    // Odd parity at four clocks per bit, data disturbed right after acceptance.
    launch(1, 8'h00);
    run_frame(1, 8'h00, 8'hFF, 1'b0, 1'b0);

    // No parity, two stop bits.
    launch(2, 8'hFF);
    run_frame(2, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Back-to-back with start held high; the held start must not disturb frame one.
    launch(0, 8'h01);
    run_frame(0, 8'h01, 8'h80, 1'b0, 1'b1);
    run_frame(0, 8'h80, 8'($urandom), 1'b0, 1'b0);

    // A start pulse in mid-frame is ignored and no second frame follows.
    d = 8'($urandom);
    launch(1, d);
    run_frame(1, d, ~d, 1'b1, 1'b0);
    d = 8'($urandom);
    launch(2, d);
    run_frame(2, d, ~d, 1'b1, 1'b0);

    // Reset while data bit 3 is on the line.
    d = 8'($urandom);
    build_frame(0, d);
    launch(0, d);
    @(posedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) start_v[0] = 1'b0;
      chk($sformatf("rst_mid tx@%0d", j), tx_v[0], exp_q[j]);
    end
    chk("rst_mid state_data", st_v[0], 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "rst_mid");
    @(negedge clk);
    check_idle(0, "rst_mid_next");
    d = 8'($urandom);
    launch(0, d);
    run_frame(0, d, 8'($urandom), 1'b0, 1'b0);

    // Reset and start on the same edge: the request is dropped.
    @(negedge clk);
    rst        = 1'b1;
    start_v[1] = 1'b1;
    data_v[1]  = 8'($urandom);
    @(negedge clk);
    rst        = 1'b0;
    start_v[1] = 1'b0;
    check_idle(1, "rst_start");
    @(negedge clk);
    check_idle(1, "rst_start_next");

    // Random bytes across all configurations.
    for (int n = 0; n < 8; n++) begin
      k = int'($urandom_range(0, 2));
      d = 8'($urandom);
      launch(k, d);
      run_frame(k, d, 8'($urandom), n[0], 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
